colour_sequencer: RTL and testbench

Parametrised playback engine for the Simon Says colour LEDs. On a `start` strobe it snapshots the round's colour sequence and plays the first `round_len` entries. Each entry is shown as a one-hot flash for `ON_CYCLES` clocks, followed by a blank gap of `OFF_CYCLES` clocks. It then pulses `done` and returns to idle, where it echoes player input. It replaces the fixed 4-colour, externally-clocked flasher and sits between the game FSM and the LED pins.

---
 rtl/colour_sequencer.sv | 156 +++++++++++++++
 tb/tb_colour_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_sequencer.sv
// Simon Says colour playback engine: snapshots a colour sequence on start and flashes it step by step.
// Optional COLOUR_SEQUENCER_ECHO_EN overlays player_input on disp_o during playback as well.
module colour_sequencer #(
  parameter  int N_COLOURS  = 4,
  parameter  int MAX_ROUNDS = 33,
  parameter  int ON_CYCLES  = 25_000_000,
  parameter  int OFF_CYCLES = 12_500_000,
  localparam int CW         = $clog2(N_COLOURS),
  localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [RW-1:0]              round_len,
  input  logic [MAX_ROUNDS*CW-1:0]   segment,
  input  logic [N_COLOURS-1:0]       player_input,
  output logic [N_COLOURS-1:0]       disp_o,
  output logic                       busy,
  output logic                       done,
  output logic [RW-1:0]              step_idx
);

  localparam int              T_MAX    = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int              TW       = $clog2(T_MAX + 1);
  localparam logic [TW-1:0]   ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]   OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [RW-1:0]   MAX_LEN  = RW'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [MAX_ROUNDS*CW-1:0]  r_seq;
  logic [RW-1:0]             r_len;
  logic [RW-1:0]             r_step;
  logic [TW-1:0]             r_timer;
  logic [N_COLOURS-1:0]      r_flash;
  logic                      r_busy;
  logic                      r_done;

  logic [RW-1:0]             w_len_clamped;
  logic [RW-1:0]             w_next_step;
  logic [CW-1:0]             w_first_colour;
  logic [CW-1:0]             w_next_colour;
  logic [N_COLOURS-1:0]      w_echo;

  // Colour codes at or above N_COLOURS match no channel and so decode to a blank step.
  function automatic logic [N_COLOURS-1:0] one_hot(input logic [CW-1:0] colour);
    logic [N_COLOURS-1:0] oh;
    oh = '0;
    for (int unsigned c = 0; c < N_COLOURS; c++) begin
      oh[c] = (colour == CW'(c));
    end
    return oh;
  endfunction

  assign w_len_clamped  = (round_len > MAX_LEN) ? MAX_LEN : round_len;
  assign w_next_step    = r_step + RW'(1);
  assign w_first_colour = segment[CW-1:0];
  assign w_next_colour  = r_seq[w_next_step*CW +: CW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_seq   <= '0;
      r_len   <= '0;
      r_step  <= '0;
      r_timer <= '0;
      r_flash <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seq   <= segment;
            r_len   <= w_len_clamped;
            r_step  <= '0;
            r_timer <= '0;
            if (w_len_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ON;
              r_busy  <= 1'b1;
              // seq_q is being loaded on this edge, so step 0 decodes straight from the input.
              r_flash <= one_hot(w_first_colour);
            end
          end
        end
        S_ON: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_flash <= '0;
            r_step  <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
          end else if (r_timer == ON_LAST) begin
            r_state <= S_OFF;
            r_timer <= '0;
            r_flash <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_OFF: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_flash <= '0;
            r_step  <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
          end else if (r_timer == OFF_LAST) begin
            r_timer <= '0;
            if (r_step == r_len - RW'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ON;
              r_step  <= w_next_step;
              r_flash <= one_hot(w_next_colour);
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_step  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef COLOUR_SEQUENCER_ECHO_EN
  assign w_echo = player_input;
`else
  assign w_echo = r_busy ? '0 : player_input;
`endif

  assign disp_o   = r_flash | w_echo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_step;

endmodule

// File: tb/tb_colour_sequencer.sv
// Directed bench for colour_sequencer: 4-colour main instance plus a 3-colour instance for blank-step/echo cases.
module tb_colour_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        start, abort;
  logic [3:0]  round_len;
  logic [15:0] segment;
  logic [3:0]  player_input;
  logic [3:0]  disp_o;
  logic        busy, done;
  logic [3:0]  step_idx;

  logic        start3;
  logic [3:0]  round_len3;
  logic [15:0] segment3;
  logic [2:0]  player_input3;
  logic [2:0]  disp3;
  logic        busy3, done3;
  logic [3:0]  step3;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef COLOUR_SEQUENCER_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  colour_sequencer #(
    .N_COLOURS (4),
    .MAX_ROUNDS(8),
    .ON_CYCLES (3),
    .OFF_CYCLES(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .round_len   (round_len),
    .segment     (segment),
    .player_input(player_input),
    .disp_o      (disp_o),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx)
  );

  colour_sequencer #(
    .N_COLOURS (3),
    .MAX_ROUNDS(8),
    .ON_CYCLES (3),
    .OFF_CYCLES(2)
  ) dut3 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start3),
    .abort       (1'b0),
    .round_len   (round_len3),
    .segment     (segment3),
    .player_input(player_input3),
    .disp_o      (disp3),
    .busy        (busy3),
    .done        (done3),
    .step_idx    (step3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Steps 2,0,3 -> flashes 0100, 0001, 1000; 3 on + 2 off per step.
  logic [3:0] exp_flash [3] = '{4'b0100, 4'b0001, 4'b1000};

  task automatic check_basic(input bit snap);
    for (int j = 0; j < 15; j++) begin
      chk("basic_disp", disp_o, ((j % 5) < 3) ? exp_flash[j / 5] : 4'b0000);
      chk("basic_busy", busy, 1);
      chk("basic_done", done, 0);
      chk("basic_step", step_idx, j / 5);
      if (snap && j == 3) begin
        segment   = 16'h0015;
        round_len = 4'd1;
        start     = 1'b1;
      end
      if (snap && j == 4) start = 1'b0;
      tick();
    end
    chk("basic_done_pulse", done, 1);
    chk("basic_busy_fall", busy, 0);
    chk("basic_disp_end", disp_o, 0);
    tick();
    chk("basic_done_clear", done, 0);
    chk("basic_step_idle", step_idx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    start = 0; abort = 0; round_len = 0; segment = 0; player_input = 0;
    start3 = 0; round_len3 = 0; segment3 = 0; player_input3 = 0;
    #12;
    chk("rst_disp", disp_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_idx, 0);
    tick();
    reset_n = 1'b1;
    tick();

    player_input = 4'b1010;
    #1;
    chk("idle_echo", disp_o, 4'b1010);
    player_input = 4'b0000;

    // Basic playback
    segment = 16'h0032; round_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check_basic(1'b0);

    // Zero length
    round_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_disp", disp_o, 0);
    tick();
    chk("len0_done_clear", done, 0);
    chk("len0_busy_after", busy, 0);

    // Length clamp 15 -> 8
    segment = 16'hFFFF; round_len = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len15_flash", disp_o, 4'b1000);
    wait_done(60, n);
    chk("len15_done_at", n, 40);
    tick();

    // Abort during step 1 ON, then restart and reset mid-op
    segment = 16'h0032; round_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    player_input = 4'b0010;
    #1;
    chk("busy_echo", disp_o, ECHO ? 4'b0011 : 4'b0001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_disp", disp_o, 4'b0010);
    chk("abort_done", done, 0);
    chk("abort_step", step_idx, 0);
    tick();
    chk("abort_no_done", done, 0);
    player_input = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_step", step_idx, 0);
    chk("restart_disp", disp_o, 4'b0100);
    chk("restart_busy", busy, 1);
    repeat (7) tick();
    chk("premid_disp", disp_o, 4'b0001);
    chk("premid_step", step_idx, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_disp", disp_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_step", step_idx, 0);
    tick();
    reset_n = 1'b1;
    tick();
    player_input = 4'b1001;
    #1;
    chk("postrst_echo", disp_o, 4'b1001);
    chk("postrst_busy", busy, 0);
    player_input = 4'b0000;

    // Abort beats timer expiry on the final OFF cycle
    segment = 16'h0000; round_len = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_prio_done", done, 0);
    chk("abort_prio_busy", busy, 0);
    tick();
    chk("abort_prio_done2", done, 0);

    // Snapshot: mid-playback segment/start changes are ignored
    segment = 16'h0032; round_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check_basic(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("snap_new_disp", disp_o, 4'b0010);
    wait_done(20, n);
    chk("snap_new_done_at", n, 5);
    tick();

    // 3-colour instance: colour 3 is blank, echo per build option
    player_input3 = 3'b001;
    segment3 = 16'h000B; round_len3 = 4'd2; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      chk("nc3_disp", disp3, ((j >= 5 && j < 8) ? 3'b100 : 3'b000) | (ECHO ? 3'b001 : 3'b000));
      chk("nc3_busy", busy3, 1);
      tick();
    end
    chk("nc3_done", done3, 1);
    chk("nc3_busy_end", busy3, 0);
    tick();
    chk("nc3_idle_echo", disp3, 3'b001);
    chk("nc3_step_idle", step3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
